// File: rtl/valu_seq_ctrl.sv
// valu_seq_ctrl
// Memory-to-memory sequencer for the 6-lane, 48-bit vector ALU. One start
// command walks `len` elements. For each element it reads A, reads B,
// presents both to the ALU and writes the result to the destination array.
//
// Ports
//   clk, rst_n            system clock (rising edge), async active-low reset
//   start, op, base_a/b/d, len
//                         command interface; all sampled only in IDLE
//   busy, done            status; done is a one-cycle completion pulse
//   mem_addr/rd/wr/wdata  single-port data memory master
//   mem_rdata             read data, valid one cycle after mem_rd
//   alu_ctrl, src_a, src_b  ALU operand/opcode drive
//   alu_result            combinational ALU output
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// RD_A   | read request for A[i]
// RD_B   | read request for B[i]; A[i] arrives and is captured
// LD_B   | B[i] arrives and is captured; memory untouched
// WR     | write ALU result to D[i]; step i or finish
// DONE   | one-cycle done pulse
module valu_seq_ctrl #(
   parameter int N  = 48,
   parameter int AW = 10,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [4:0]    op,
   input  logic [AW-1:0] base_a,
   input  logic [AW-1:0] base_b,
   input  logic [AW-1:0] base_d,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [N-1:0]  mem_wdata,
   input  logic [N-1:0]  mem_rdata,
   output logic [4:0]    alu_ctrl,
   output logic [N-1:0]  src_a,
   output logic [N-1:0]  src_b,
   input  logic [N-1:0]  alu_result
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_LD_B, S_WR, S_DONE
   } state_t;

   state_t        state_q;
   logic [LW-1:0] i_q;
   logic [LW-1:0] len_q;
   logic [AW-1:0] base_a_q, base_b_q, base_d_q;
   logic [4:0]    alu_ctrl_q;
   logic [N-1:0]  src_a_q, src_b_q;
   logic          busy_q, done_q, mem_rd_q, mem_wr_q;
   logic [AW-1:0] mem_addr_q;

   logic [LW-1:0] i_inc_d;
   logic          last_d;
   logic [AW-1:0] addr_b_d, addr_d_d, addr_a_next_d;

   // Address sums are AW bits wide, so they wrap modulo 2^AW on their own.
   assign i_inc_d       = i_q + LW'(1);
   assign last_d        = (i_q == (len_q - LW'(1)));
   assign addr_b_d      = base_b_q + AW'(i_q);
   assign addr_d_d      = base_d_q + AW'(i_q);
   assign addr_a_next_d = base_a_q + AW'(i_inc_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         i_q        <= '0;
         len_q      <= '0;
         base_a_q   <= '0;
         base_b_q   <= '0;
         base_d_q   <= '0;
         alu_ctrl_q <= '0;
         src_a_q    <= '0;
         src_b_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  i_q        <= '0;
                  len_q      <= len;
                  base_a_q   <= base_a;
                  base_b_q   <= base_b;
                  base_d_q   <= base_d;
                  alu_ctrl_q <= op;
                  busy_q     <= 1'b1;
                  if (len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_RD_A;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= base_a;
                  end
               end
            end
            S_RD_A: begin
               state_q    <= S_RD_B;
               mem_addr_q <= addr_b_d;
            end
            S_RD_B: begin
               state_q    <= S_LD_B;
               src_a_q    <= mem_rdata;
               mem_rd_q   <= 1'b0;
               mem_addr_q <= '0;
            end
            S_LD_B: begin
               state_q    <= S_WR;
               src_b_q    <= mem_rdata;
               mem_wr_q   <= 1'b1;
               mem_addr_q <= addr_d_d;
            end
            S_WR: begin
               mem_wr_q <= 1'b0;
               if (last_d) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  mem_addr_q <= '0;
               end else begin
                  state_q    <= S_RD_A;
                  i_q        <= i_inc_d;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= addr_a_next_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q    <= S_IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               mem_rd_q   <= 1'b0;
               mem_wr_q   <= 1'b0;
               mem_addr_q <= '0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_rd   = mem_rd_q;
   assign mem_wr   = mem_wr_q;
   assign mem_addr = mem_addr_q;
   assign alu_ctrl = alu_ctrl_q;
   assign src_a    = src_a_q;
   assign src_b    = src_b_q;
   // The ALU result only settles after src_b loads at the LD_B->WR edge, so
   // write data is a gated pass-through rather than a register.
   assign mem_wdata = (state_q == S_WR) ? alu_result : '0;

endmodule

// File: doc/valu_seq_ctrl.md
Name: valu_seq_ctrl

Overview:
- Memory-to-memory sequencer for the 48-bit, 6-lane SIMD vector ALU.
- On one start command it walks `len` vector elements. Per element it reads operand A and operand B from a single-port data memory, presents them to the vector ALU, and writes the ALU result back to a destination array.
- Sits between the control unit, which issues start/op/base addresses, and the shared vector data memory. Owns the ALU's alu_ctrl, src_A and src_B inputs for the duration of the operation.

Parameters:
- N, 48, vector word width (6 lanes x 8 bits), same as the vector ALU.
- AW, 10, memory word-address width.
- LW, 8, element-count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  5  ALU operation code; latched at start.
- base_a  in  AW  word address of operand-A array; latched at start.
- base_b  in  AW  word address of operand-B array; latched at start.
- base_d  in  AW  word address of destination array; latched at start.
- len  in  LW  number of elements; latched at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  AW  memory word address.
- mem_rd  out  1  read strobe; data returns on mem_rdata the following cycle.
- mem_wr  out  1  write strobe.
- mem_wdata  out  N  write data.
- mem_rdata  in  N  read data, valid one cycle after mem_rd.
- alu_ctrl  out  5  to vector ALU; equals latched op.
- src_a  out  N  to vector ALU; operand-A register.
- src_b  out  N  to vector ALU; operand-B register.
- alu_result  in  N  from vector ALU; combinational in src_a/src_b/alu_ctrl.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, alu_ctrl=0, src_a=0, src_b=0.
  - Element index and all latched fields clear.
  - A write in flight is dropped.
- States: IDLE, RD_A, RD_B, LD_B, WR, DONE.
- IDLE:
  - If start=1, latch op/base_a/base_b/base_d/len and clear index i.
  - Next state is DONE if len==0, else RD_A.
- RD_A: mem_rd=1, mem_addr=base_a+i. Next: RD_B.
- RD_B: mem_rd=1, mem_addr=base_b+i; src_a register loads mem_rdata. Next: LD_B.
- LD_B: src_b register loads mem_rdata; no memory access. Next: WR.
- WR:
  - mem_wr=1, mem_addr=base_d+i, mem_wdata=alu_result.
  - If i==len-1, next state is DONE; otherwise i increments and next state is RD_A.
- DONE: done=1 for exactly one cycle, busy still 1. Next: IDLE.
- Strobe exclusivity: mem_rd and mem_wr are never high together. Both are 0 and mem_addr=0 in IDLE, LD_B and DONE; mem_wdata=0 outside WR.
- Timing (start sampled at edge 0):
  - Element k occupies cycles 4k+1..4k+4; its write happens in cycle 4k+4.
  - done is high in cycle 4*len+1; busy falls in cycle 4*len+2.
  - len=0: done in cycle 1, no memory access.
- Address arithmetic: base+i computed modulo 2^AW; wraps silently past 2^AW-1.
- len is treated as unsigned; len=2^LW-1 is legal.
- start while busy (including in DONE) is ignored; latched fields do not change. Inputs other than mem_rdata/alu_result are don't-care while busy.
- alu_ctrl holds the latched op from the cycle after start until the next accepted start; it is not cleared at DONE.
- src_a/src_b hold their last values after completion.
- A/B/D arrays may overlap; because of the per-element read-before-write order, an in-place op (base_d==base_a) is well defined.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, start=0 -> all outputs 0, busy=0 for 10 cycles.
- Three-element run with the bench ALU model computing src_a^src_b: len=3, base_a=0x010, base_b=0x020, base_d=0x030, mem[0x010..0x012]=0x0000_0000_00FF_0F0F.., mem[0x020..]=0xFFFF_FFFF_FFFF.. -> writes to 0x030,0x031,0x032 in cycles 4,8,12 with the XOR values; done in cycle 13 only; alu_ctrl=op throughout.
- len=0 -> done in cycle 1, mem_rd/mem_wr never asserted, busy high cycles 1 only.
- Address wrap: AW=10, base_a=0x3FF, base_b=0x3FE, base_d=0x3FF, len=2 -> element 1 reads A at 0x000 and B at 0x3FF, writes at 0x000; element 0's in-place write at 0x3FF occurs before element 1's B read of 0x3FF, which returns the new value.
- start pulsed in cycles 2 and 13 of a len=3 run with different op/bases -> ignored; addresses and alu_ctrl unchanged; exactly one done.
- rst_n asserted asynchronously mid-cycle during LD_B of element 1 -> outputs 0 immediately, no write to base_d+1; a new start after release runs correctly from element 0.
